// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver and IF-stage dynamic predictor for the 5-stage core.
// Direct-mapped table of 2-bit saturating counters indexed by PC[IDX_W+1:2], plus saturating perf counters.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              ex_mispredict,
  output logic [XLEN-1:0]   ex_redirect_pc,
  output logic              ex_illegal,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             legal;
  logic             taken;
  logic             upd;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_nxt;
  logic             unused_if_pc_bits;

  assign if_idx            = if_pc[IDX_W+1:2];
  assign ex_idx            = ex_pc[IDX_W+1:2];
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Async table read: a same-cycle update is not bypassed to the lookup.
  assign if_pred_taken = bht[if_idx][1];

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_funct3)
      3'd0:    taken = (ex_rs1 == ex_rs2);
      3'd1:    taken = (ex_rs1 != ex_rs2);
      3'd4:    taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'd5:    taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'd6:    taken = (ex_rs1 <  ex_rs2);
      3'd7:    taken = (ex_rs1 >= ex_rs2);
      default: legal = 1'b0;
    endcase
  end

  assign ex_taken       = taken;
  assign ex_illegal     = ex_valid & ~legal;
  assign ex_mispredict  = ex_valid & legal & (taken != ex_pred_taken);
  assign ex_redirect_pc = taken ? ex_target : ex_pc + XLEN'(4);
  assign upd            = ex_valid & legal;

  always_comb begin
    cnt_cur = bht[ex_idx];
    cnt_nxt = cnt_cur;
    if (taken && cnt_cur != 2'b11)
      cnt_nxt = cnt_cur + 2'b01;
    else if (!taken && cnt_cur != 2'b00)
      cnt_nxt = cnt_cur - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= CNT_INIT;
    end else if (upd) begin
      bht[ex_idx] <= cnt_nxt;
    end
  end

  // Perf counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd && perf_branches != '1)
        perf_branches <= perf_branches + PERF_W'(1);
      if (ex_mispredict && perf_mispredicts != '1)
        perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed vectors push expected outputs, a negedge monitor pops and compares.
// Perf width is narrowed so saturation is reachable in a short run.
module tb_branch_predict_unit;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   if_pc, ex_pc, ex_rs1, ex_rs2, ex_target, ex_redirect_pc;
  logic [2:0]    ex_funct3;
  logic          ex_valid, ex_pred_taken;
  logic          if_pred_taken, ex_taken, ex_mispredict, ex_illegal;
  logic [PW-1:0] perf_branches, perf_mispredicts;

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_INIT(2'b01), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .ex_illegal(ex_illegal), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic          pred;
    logic          taken;
    logic          mis;
    logic          ill;
    logic [31:0]   redir;
    logic [PW-1:0] pb;
    logic [PW-1:0] pm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_pb  = 0;
  int   m_pm  = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: combinational outputs are stable half a cycle after the driver updates inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("if_pred_taken", e.id, 32'(if_pred_taken), 32'(e.pred));
        chk("ex_taken", e.id, 32'(ex_taken), 32'(e.taken));
        chk("ex_mispredict", e.id, 32'(ex_mispredict), 32'(e.mis));
        chk("ex_illegal", e.id, 32'(ex_illegal), 32'(e.ill));
        chk("ex_redirect_pc", e.id, ex_redirect_pc, e.redir);
        chk("perf_branches", e.id, 32'(perf_branches), 32'(e.pb));
        chk("perf_mispredicts", e.id, 32'(perf_mispredicts), 32'(e.pm));
      end
    end
  end

  task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tgt, input logic pp,
                       input logic e_pred, input logic e_taken, input logic [31:0] e_redir,
                       input logic e_mis, input logic e_ill);
    exp_t e;
    @(posedge clk);
    #1;
    if_pc = ipc; ex_valid = v; ex_pc = pc; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = b; ex_target = tgt; ex_pred_taken = pp;
    e.id = n_vec; e.pred = e_pred; e.taken = e_taken; e.mis = e_mis; e.ill = e_ill;
    e.redir = e_redir; e.pb = PW'(m_pb); e.pm = PW'(m_pm);
    q.push_back(e);
    n_vec++;
    // Expected perf effect lands at the next edge unless reset is held through it.
    if (rst_n && v && !e_ill) begin
      if (m_pb < 15) m_pb++;
      if (e_mis && m_pm < 15) m_pm++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_target = '0; ex_pred_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //     if_pc         v     ex_pc         f3    rs1           rs2           target        pp    pred  tkn   redir         mis   ill
    drive(32'h0000_0040, 1'b0, 32'h0000_0000, 3'd0, 32'h0,        32'h0,        32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    // Signed vs unsigned compares with -1 / 1, then equality forms.
    drive(32'h0000_003C, 1'b1, 32'h0000_0080, 3'd4, 32'hFFFF_FFFF, 32'h1,       32'h0000_1000, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
    drive(32'h0000_0080, 1'b1, 32'h0000_0084, 3'd6, 32'hFFFF_FFFF, 32'h1,       32'h0000_1000, 1'b0, 1'b1, 1'b0, 32'h0000_0088, 1'b0, 1'b0);
    drive(32'h0000_0084, 1'b1, 32'h0000_0088, 3'd5, 32'hFFFF_FFFF, 32'h1,       32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0000_008C, 1'b1, 1'b0);
    drive(32'h0000_008C, 1'b1, 32'h0000_008C, 3'd7, 32'hFFFF_FFFF, 32'h1,       32'h0000_2000, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
    drive(32'h0000_008C, 1'b1, 32'h0000_0090, 3'd0, 32'h1234,      32'h1234,    32'h0000_3000, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    drive(32'h0000_0000, 1'b1, 32'h0000_0094, 3'd1, 32'h1234,      32'h1234,    32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'h0000_0098, 1'b1, 1'b0);
    // Saturation on entry 16: 01 -> 10 -> 11 -> 11 -> 11, then down to 10.
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h7,        32'h7,        32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h7,        32'h7,        32'h0000_0500, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h7,        32'h7,        32'h0000_0500, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h7,        32'h7,        32'h0000_0500, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h1,        32'h2,        32'h0000_0500, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b0);
    drive(32'h0000_0040, 1'b0, 32'h0000_0040, 3'd0, 32'h1,        32'h2,        32'h0000_0500, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    // Mispredict redirects.
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd1, 32'h1,        32'h2,        32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd1, 32'h5,        32'h5,        32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b0);
    // Illegal and invalid slots must leave entry 16 at 10 and perf untouched.
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd2, 32'h5,        32'h5,        32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b1);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd3, 32'h1,        32'h2,        32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b1);
    drive(32'h0000_0040, 1'b0, 32'h0000_0040, 3'd1, 32'h1,        32'h2,        32'h0000_0100, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b0, 32'h0000_0040, 3'd3, 32'h1,        32'h2,        32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b1, 32'h0000_0040, 3'd0, 32'h1,        32'h2,        32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b0);
    drive(32'h0000_0040, 1'b0, 32'h0000_0040, 3'd0, 32'h0,        32'h0,        32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    // Aliasing 0x0 / 0x100 and perf_branches saturation.
    drive(32'h0000_0100, 1'b1, 32'h0000_0000, 3'd0, 32'h7,        32'h7,        32'h0000_0600, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 1'b1, 1'b0);
    drive(32'h0000_0100, 1'b1, 32'h0000_0100, 3'd0, 32'h7,        32'h7,        32'h0000_0600, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
    drive(32'h0000_0000, 1'b0, 32'h0000_0100, 3'd0, 32'h7,        32'h7,        32'h0000_0600, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      drive(32'h0000_003C, 1'b1, 32'h0000_00C0, 3'd1, 32'h1,      32'h2,        32'h0000_0700, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 1'b1, 1'b0);
    drive(32'h0000_003C, 1'b0, 32'hFFFF_FFFC, 3'd1, 32'h9,        32'h9,        32'h0000_0700, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

    // Mid-run reset: whole table back to 01, perf to 0, in-flight update dropped.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_pb  = 0;
    m_pm  = 0;
    for (int i = 0; i < 64; i++)
      drive(32'(i * 4), 1'b0, 32'h0000_0000, 3'd0, 32'h1,         32'h2,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
    drive(32'h0000_00C0, 1'b1, 32'h0000_00C0, 3'd0, 32'h3,        32'h3,        32'h0000_0800, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b0);
    drive(32'h0000_00C0, 1'b0, 32'h0000_00C0, 3'd0, 32'h3,        32'h3,        32'h0000_0800, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(32'h0000_00C0, 1'b1, 32'h0000_00C0, 3'd0, 32'h3,        32'h3,        32'h0000_0800, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b1, 1'b0);
    drive(32'h0000_00C0, 1'b0, 32'h0000_00C0, 3'd0, 32'h3,        32'h3,        32'h0000_0800, 1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0);

    begin
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      n_cmp++;
      if (q.size() > 0) begin
        n_bad++;
        $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
